// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The optional WB_PENDING_EN build adds no package content.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(ZERO_REG);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources and the register-file write port.
// pending_mask only exists when WB_PENDING_EN is defined.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              regWR;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] dataWrite;
  logic              grant_src;
`ifdef WB_PENDING_EN
  logic [2**ADDR_W-1:0] pending_mask;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, regWR, Rd, dataWrite, grant_src
`ifdef WB_PENDING_EN
    , input pending_mask
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, regWR, Rd, dataWrite, grant_src
`ifdef WB_PENDING_EN
    , output pending_mask
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback holding slot; a released slot may be refilled on the same edge.
// Unaffected by WB_PENDING_EN.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  wb_req_t i_req,
  input  logic    i_release,
  output logic    o_ready,
  output logic    o_capture,
  output logic    o_full,
  output wb_req_t o_req
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t r_state;
  wb_req_t     r_req;

  assign o_ready   = (r_state == EMPTY) || i_release;
  assign o_capture = i_valid && o_ready;
  assign o_full    = (r_state == FULL);
  assign o_req     = r_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_req   <= '0;
    end else if (o_capture) begin
      r_state <= FULL;
      r_req   <= i_req;
    end else if (i_release) begin
      r_state <= EMPTY;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with WAW age override and zero-register drop.
// Define WB_PENDING_EN to expose pending_mask for the hazard unit.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  wb_req_t w_alu_in, w_mem_in, w_alu_slot, w_mem_slot, w_sel_req;
  logic    w_alu_full, w_mem_full, w_alu_cap, w_mem_cap;
  logic    w_alu_rel, w_mem_rel, w_alu_drop, w_mem_drop;
  logic    w_alu_live, w_mem_live, w_grant_vld;
  logic    w_alu_ready, w_mem_ready, w_alu_stay, w_mem_stay;
  src_t    w_grant_src;

  logic              r_regwr;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  src_t              r_src;
  src_t              r_last_grant;
  logic              r_mem_older;

  assign w_alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
  assign w_mem_in = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_slot u_alu_slot (
    .clk(clk), .rst(rst), .i_valid(bus.alu_valid), .i_req(w_alu_in),
    .i_release(w_alu_rel), .o_ready(w_alu_ready), .o_capture(w_alu_cap),
    .o_full(w_alu_full), .o_req(w_alu_slot)
  );

  wb_slot u_mem_slot (
    .clk(clk), .rst(rst), .i_valid(bus.mem_valid), .i_req(w_mem_in),
    .i_release(w_mem_rel), .o_ready(w_mem_ready), .o_capture(w_mem_cap),
    .o_full(w_mem_full), .o_req(w_mem_slot)
  );

  // Same destination means WAW: age decides; otherwise strict alternation.
  always_comb begin
    w_alu_drop  = w_alu_full && (w_alu_slot.rd == ZERO_RD);
    w_mem_drop  = w_mem_full && (w_mem_slot.rd == ZERO_RD);
    w_alu_live  = w_alu_full && !w_alu_drop;
    w_mem_live  = w_mem_full && !w_mem_drop;
    w_grant_vld = w_alu_live || w_mem_live;
    w_grant_src = SRC_ALU;
    if (w_alu_live && w_mem_live) begin
      if (w_alu_slot.rd == w_mem_slot.rd) begin
        if (r_mem_older) w_grant_src = SRC_MEM;
      end else if (r_last_grant == SRC_ALU) begin
        w_grant_src = SRC_MEM;
      end
    end else if (w_mem_live) begin
      w_grant_src = SRC_MEM;
    end
    w_alu_rel  = w_alu_drop || (w_grant_vld && (w_grant_src == SRC_ALU));
    w_mem_rel  = w_mem_drop || (w_grant_vld && (w_grant_src == SRC_MEM));
    w_alu_stay = w_alu_full && !w_alu_rel;
    w_mem_stay = w_mem_full && !w_mem_rel;
    w_sel_req  = (w_grant_src == SRC_MEM) ? w_mem_slot : w_alu_slot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwr      <= 1'b0;
      r_rd         <= '0;
      r_data       <= '0;
      r_src        <= SRC_ALU;
      r_last_grant <= SRC_ALU;
      r_mem_older  <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_regwr      <= 1'b1;
        r_rd         <= w_sel_req.rd;
        r_data       <= w_sel_req.data;
        r_src        <= w_grant_src;
        r_last_grant <= w_grant_src;
      end else begin
        r_regwr <= 1'b0;
      end
      // Age only matters while both slots are full; a survivor is older than a new capture.
      if (w_alu_cap && w_mem_cap) begin
        r_mem_older <= 1'b1;
      end else if (w_mem_cap) begin
        r_mem_older <= !w_alu_stay;
      end else if (w_alu_cap) begin
        r_mem_older <= w_mem_stay;
      end
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.regWR     = r_regwr;
  assign bus.Rd        = r_rd;
  assign bus.dataWrite = r_data;
  assign bus.grant_src = r_src;

`ifdef WB_PENDING_EN
  logic [2**ADDR_W-1:0] w_pending;

  always_comb begin
    w_pending = '0;
    if (w_alu_live) w_pending[w_alu_slot.rd] = 1'b1;
    if (w_mem_live) w_pending[w_mem_slot.rd] = 1'b1;
    if (r_regwr)    w_pending[r_rd] = 1'b1;
  end

  assign bus.pending_mask = w_pending;
`endif
endmodule
